mp_ram: RTL and testbench
=========================

MP_RAM -- requirements
Module: mp_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word address width.
REQ-002 SHALL have parameter NUM_COL, default 4, independently writeable columns per word.
REQ-003 SHALL have parameter COL_WIDTH, default 8, bits per column; DATA_WIDTH = NUM_COL*COL_WIDTH.
REQ-004 SHALL have parameter NUM_PORTS, default 4, logical requesters, legal range 2..8.
REQ-005 SHALL have parameter PIPELINE_DEPTH, default 1, extra output register stages, legal range 0..3.
REQ-006 SHALL have parameters CASCADE_DEPTH (default 4), USE_PRELOAD (default 0) and PRELOAD_FILE (default ""), all passed to the storage array.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-009 SHALL have port req_valid, input, [NUM_PORTS], request present per requester.
REQ-010 SHALL have port req_ready, output, [NUM_PORTS], request accepted this cycle.
REQ-011 SHALL have port req_addr, input, [NUM_PORTS][ADDR_WIDTH], word address.
REQ-012 SHALL have port req_wbe, input, [NUM_PORTS][NUM_COL], column write enables; all-zero means read.
REQ-013 SHALL have port req_wdata, input, [NUM_PORTS][DATA_WIDTH], write data.
REQ-014 SHALL have port rsp_valid, output, [NUM_PORTS], read data valid.
REQ-015 SHALL have port rsp_rdata, output, [NUM_PORTS][DATA_WIDTH], read data; don't-care while rsp_valid is low.

Function
REQ-016 SHALL accept a request on requester i in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 SHALL drive req_ready combinationally from the current requests and the arbitration pointer, with no dependence on any response state.
REQ-018 SHALL grant physical port A to the first valid requester found scanning circularly from the pointer.
REQ-019 SHALL grant physical port B to the next valid requester on the same scan, giving at most two grants per cycle.
REQ-020 SHALL withhold the port B grant when both grants target the same address and either is a write; that requester waits.
REQ-021 SHALL, after any grant, advance the pointer to one past the last granted requester modulo NUM_PORTS; with no grant the pointer holds.
REQ-022 SHALL update only the columns with wbe set on an accepted write, and SHALL produce no response for a write.
REQ-023 SHALL, for an accepted read, assert rsp_valid[i] for exactly one cycle, exactly 1+PIPELINE_DEPTH cycles after acceptance.
REQ-024 SHALL return data on a read that reflects every write accepted in earlier cycles.
REQ-025 SHALL track the requester id and valid bit for each physical port through a shift register of depth 1+PIPELINE_DEPTH, and SHALL route data by that id.
REQ-026 SHALL NOT apply backpressure on responses; requesters must sink rsp_valid.
REQ-027 SHALL return responses for one requester in acceptance order, at most one per cycle.

Reset
REQ-028 SHALL, on rst, set the pointer to 0 and clear all in-flight valid bits; rsp_valid reads all zero in the cycle after rst is sampled.
REQ-029 SHALL drop any read in flight when rst is asserted; no rsp_valid for it ever appears.
REQ-030 SHALL hold req_ready all zero while rst is high.
REQ-031 SHALL leave memory contents unchanged across reset.

Structure
REQ-032 SHALL instantiate the existing tdp_ram once as storage, with PIPELINE_DEPTH and the preload and cascade parameters passed through.
REQ-033 SHALL keep the id width ($clog2(NUM_PORTS)) and all parameter-dependent types local to the module; nothing is added to the shared package.
REQ-034 SHALL implement the arbitration (pointer, two-grant scan, conflict check) inline, with no extra sub-module.

Verification
REQ-035 Setup NUM_PORTS=4, PIPELINE_DEPTH=1: port 0 writes addr 5, wbe 1111, data 0xDEADBEEF; then port 2 reads addr 5 -> rsp_valid[2] high exactly 2 cycles after acceptance with rdata 0xDEADBEEF.
REQ-036 Port 1 writes addr 5, wbe 0010, data 0x0000AB00; then a read of addr 5 -> 0xDEADABEF.
REQ-037 All 4 requesters hold valid reads from reset -> grants {0,1}, {2,3}, {0,1} on consecutive cycles, with each rsp_valid landing 2 cycles after its grant.
REQ-038 Same cycle, port 0 writes addr 9 with 0x12345678 and port 1 reads addr 9 -> only req_ready[0] is high; port 1 is granted the next cycle and returns 0x12345678.
REQ-039 A read accepted on port 3, then rst high for one cycle in the following cycle -> rsp_valid[3] never asserts; a read of addr 5 after reset still returns 0xDEADABEF.
REQ-040 PIPELINE_DEPTH=0 rerun of REQ-035 -> rsp_valid[2] high exactly 1 cycle after acceptance.

Source files
------------

// File: rtl/mp_ram_pkg.sv
// Shared definitions for the multi-port RAM slice: requester-count limits,
// pipeline limits and the request operation type.
package mp_ram_pkg;

  localparam int MIN_PORTS          = 2;
  localparam int MAX_PORTS          = 8;
  localparam int MAX_PIPELINE_DEPTH = 3;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/tdp_ram.sv
// True dual-port RAM with per-column write enables, read-first behaviour and
// 1+PIPELINE_DEPTH cycles of read latency on each port.
module tdp_ram #(
  parameter int    ADDR_WIDTH     = 10,
  parameter int    NUM_COL        = 4,
  parameter int    COL_WIDTH      = 8,
  parameter int    PIPELINE_DEPTH = 1,
  parameter int    CASCADE_DEPTH  = 4,
  parameter int    USE_PRELOAD    = 0,
  parameter string PRELOAD_FILE   = "",
  localparam int   DATA_WIDTH     = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  en_a,
  input  logic [NUM_COL-1:0]    we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  en_b,
  input  logic [NUM_COL-1:0]    we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  // Cascade and preload settings are consumed by the implementation flow;
  // here they are only checked for consistency at elaboration.
  if (CASCADE_DEPTH < 1) begin : g_bad_cascade
    $error("tdp_ram: CASCADE_DEPTH must be at least 1");
  end
  if (USE_PRELOAD != 0 && PRELOAD_FILE == "") begin : g_bad_preload
    $error("tdp_ram: USE_PRELOAD set without PRELOAD_FILE");
  end

  logic [DATA_WIDTH-1:0] mem    [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] pipe_a [PIPELINE_DEPTH+1];
  logic [DATA_WIDTH-1:0] pipe_b [PIPELINE_DEPTH+1];
  logic [DATA_WIDTH-1:0] mask_a, mask_b;
  logic [DATA_WIDTH-1:0] merged_a, merged_b;

  always_comb begin
    mask_a = '0;
    mask_b = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      mask_a[c*COL_WIDTH +: COL_WIDTH] = {COL_WIDTH{we_a[c]}};
      mask_b[c*COL_WIDTH +: COL_WIDTH] = {COL_WIDTH{we_b[c]}};
    end
    merged_a = (mem[addr_a] & ~mask_a) | (wdata_a & mask_a);
    merged_b = (mem[addr_b] & ~mask_b) | (wdata_b & mask_b);
  end

  always_ff @(posedge clk) begin
    if (en_a) begin
      pipe_a[0] <= mem[addr_a];
      if (|we_a) mem[addr_a] <= merged_a;
    end
    if (en_b) begin
      pipe_b[0] <= mem[addr_b];
      if (|we_b) mem[addr_b] <= merged_b;
    end
  end

  for (genvar s = 1; s <= PIPELINE_DEPTH; s++) begin : g_pipe
    always_ff @(posedge clk) begin
      pipe_a[s] <= pipe_a[s-1];
      pipe_b[s] <= pipe_b[s-1];
    end
  end

  assign rdata_a = pipe_a[PIPELINE_DEPTH];
  assign rdata_b = pipe_b[PIPELINE_DEPTH];

endmodule

// File: rtl/mp_ram.sv
// Multi-requester RAM: round-robin arbitration of NUM_PORTS requesters onto the
// two physical ports of a tdp_ram, with read responses routed back by id.
module mp_ram
  import mp_ram_pkg::*;
#(
  parameter int    ADDR_WIDTH     = 10,
  parameter int    NUM_COL        = 4,
  parameter int    COL_WIDTH      = 8,
  parameter int    NUM_PORTS      = 4,
  parameter int    PIPELINE_DEPTH = 1,
  parameter int    CASCADE_DEPTH  = 4,
  parameter int    USE_PRELOAD    = 0,
  parameter string PRELOAD_FILE   = "",
  localparam int   DATA_WIDTH     = NUM_COL * COL_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  output logic [NUM_PORTS-1:0]                  req_ready,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][NUM_COL-1:0]     req_wbe,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]                  rsp_valid,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_rdata
);

  localparam int ID_W = $clog2(NUM_PORTS);
  localparam int LAT  = 1 + PIPELINE_DEPTH;

  typedef logic [ID_W-1:0] id_t;
  typedef struct packed {
    logic valid;
    id_t  id;
  } slot_t;

  if (NUM_PORTS < MIN_PORTS || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("mp_ram: NUM_PORTS out of range");
  end
  if (PIPELINE_DEPTH < 0 || PIPELINE_DEPTH > MAX_PIPELINE_DEPTH) begin : g_bad_depth
    $error("mp_ram: PIPELINE_DEPTH out of range");
  end

  id_t   ptr, ptr_next, a_id, b_id, cand;
  logic  a_found, b_found, b_conflict, grant_b;
  op_e   a_op, b_op;
  slot_t slot_a [LAT];
  slot_t slot_b [LAT];
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

  // Circular scan from the pointer: first valid requester takes port A, the
  // next one takes port B. Reset masks every request.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_id    = '0;
    b_id    = '0;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = id_t'((int'(ptr) + k) % NUM_PORTS);
      if (!rst && req_valid[cand]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_id    = cand;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_id    = cand;
        end
      end
    end
  end

  assign a_op       = (|req_wbe[a_id]) ? OP_WRITE : OP_READ;
  assign b_op       = (|req_wbe[b_id]) ? OP_WRITE : OP_READ;
  assign b_conflict = (req_addr[a_id] == req_addr[b_id]) &&
                      (a_op == OP_WRITE || b_op == OP_WRITE);
  assign grant_b    = b_found && !b_conflict;

  always_comb begin
    req_ready = '0;
    if (a_found) req_ready[a_id] = 1'b1;
    if (grant_b) req_ready[b_id] = 1'b1;
  end

  always_comb begin
    ptr_next = ptr;
    if (grant_b)      ptr_next = id_t'((int'(b_id) + 1) % NUM_PORTS);
    else if (a_found) ptr_next = id_t'((int'(a_id) + 1) % NUM_PORTS);
  end

  // Stage 0 of the id/valid tracker is loaded at acceptance; only reads
  // produce a response, so writes enter as invalid slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      slot_a[0] <= '0;
      slot_b[0] <= '0;
    end else begin
      ptr       <= ptr_next;
      slot_a[0] <= slot_t'{valid: a_found && (a_op == OP_READ), id: a_id};
      slot_b[0] <= slot_t'{valid: grant_b && (b_op == OP_READ), id: b_id};
    end
  end

  for (genvar s = 1; s < LAT; s++) begin : g_track
    always_ff @(posedge clk) begin
      if (rst) begin
        slot_a[s] <= '0;
        slot_b[s] <= '0;
      end else begin
        slot_a[s] <= slot_a[s-1];
        slot_b[s] <= slot_b[s-1];
      end
    end
  end

  tdp_ram #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NUM_COL        (NUM_COL),
    .COL_WIDTH      (COL_WIDTH),
    .PIPELINE_DEPTH (PIPELINE_DEPTH),
    .CASCADE_DEPTH  (CASCADE_DEPTH),
    .USE_PRELOAD    (USE_PRELOAD),
    .PRELOAD_FILE   (PRELOAD_FILE)
  ) u_ram (
    .clk     (clk),
    .en_a    (a_found),
    .we_a    (req_wbe[a_id]),
    .addr_a  (req_addr[a_id]),
    .wdata_a (req_wdata[a_id]),
    .rdata_a (rdata_a),
    .en_b    (grant_b),
    .we_b    (req_wbe[b_id]),
    .addr_b  (req_addr[b_id]),
    .wdata_b (req_wdata[b_id]),
    .rdata_b (rdata_b)
  );

  // The two physical ports always carry different requesters in a given
  // cycle, so their responses never collide on one output lane.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (slot_a[LAT-1].valid) begin
      rsp_valid[slot_a[LAT-1].id] = 1'b1;
      rsp_rdata[slot_a[LAT-1].id] = rdata_a;
    end
    if (slot_b[LAT-1].valid) begin
      rsp_valid[slot_b[LAT-1].id] = 1'b1;
      rsp_rdata[slot_b[LAT-1].id] = rdata_b;
    end
  end

endmodule

// File: tb/tb_mp_ram.sv
// Directed bench for mp_ram: one instance with PIPELINE_DEPTH=1 and one with
// PIPELINE_DEPTH=0, both driven by the same request stream.
module tb_mp_ram;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0]            req_valid;
  logic [3:0][9:0]       req_addr;
  logic [3:0][3:0]       req_wbe;
  logic [3:0][31:0]      req_wdata;
  logic [3:0]            ready1, ready0;
  logic [3:0]            valid1, valid0;
  logic [3:0][31:0]      rdata1, rdata0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mp_ram #(.NUM_PORTS(4), .PIPELINE_DEPTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (ready1),
    .req_addr  (req_addr),
    .req_wbe   (req_wbe),
    .req_wdata (req_wdata),
    .rsp_valid (valid1),
    .rsp_rdata (rdata1)
  );

  mp_ram #(.NUM_PORTS(4), .PIPELINE_DEPTH(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (ready0),
    .req_addr  (req_addr),
    .req_wbe   (req_wbe),
    .req_wdata (req_wdata),
    .rsp_valid (valid0),
    .rsp_rdata (rdata0)
  );

  task automatic applyStimulus(input int port, input logic valid, input logic [9:0] addr,
                               input logic [3:0] wbe, input logic [31:0] wdata);
    req_valid[port] = valid;
    req_addr[port]  = addr;
    req_wbe[port]   = wbe;
    req_wdata[port] = wdata;
  endtask

  task automatic idleAll();
    for (int p = 0; p < 4; p++) applyStimulus(p, 1'b0, 10'd0, 4'd0, 32'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    idleAll();
    applyStimulus(0, 1'b1, 10'd5, 4'h0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] reset phase");
    checkOutput("ready_during_rst", 32'(ready1), 32'h0);
    checkOutput("rsp_after_rst_pd1", 32'(valid1), 32'h0);
    checkOutput("rsp_after_rst_pd0", 32'(valid0), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    idleAll();

    // Full write then read-back on another requester; pointer 0 -> 1 -> 3.
    @(negedge clk);
    applyStimulus(0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    #1 checkOutput("wr5_ready", 32'(ready1), 32'h1);
    @(negedge clk);
    idleAll();
    applyStimulus(2, 1'b1, 10'd5, 4'h0, 32'd0);
    #1 checkOutput("rd5_ready", 32'(ready1), 32'h4);
    @(negedge clk);
    idleAll();
    #1;
    checkOutput("rd5_pd1_not_early", 32'(valid1), 32'h0);
    checkOutput("rd5_pd0_valid", 32'(valid0), 32'h4);
    checkOutput("rd5_pd0_data", rdata0[2], 32'hDEADBEEF);
    @(negedge clk);
    #1;
    checkOutput("rd5_pd1_valid", 32'(valid1), 32'h4);
    checkOutput("rd5_pd1_data", rdata1[2], 32'hDEADBEEF);
    checkOutput("rd5_pd0_one_shot", 32'(valid0), 32'h0);
    @(negedge clk);
    #1 checkOutput("rd5_pd1_one_shot", 32'(valid1), 32'h0);

    // Single-column write; pointer 3 scans 3,0,1.
    @(negedge clk);
    applyStimulus(1, 1'b1, 10'd5, 4'b0010, 32'h0000AB00);
    #1 checkOutput("col_wr_ready", 32'(ready1), 32'h2);
    @(negedge clk);
    idleAll();
    applyStimulus(1, 1'b1, 10'd5, 4'h0, 32'd0);
    #1 checkOutput("col_rd_ready", 32'(ready1), 32'h2);
    @(negedge clk);
    idleAll();
    @(negedge clk);
    #1;
    checkOutput("col_rd_valid", 32'(valid1), 32'h2);
    checkOutput("col_rd_data", rdata1[1], 32'hDEADABEF);

    // Second known word for routing checks; pointer 2 scans 2,3.
    @(negedge clk);
    applyStimulus(3, 1'b1, 10'd6, 4'hF, 32'hCAFE0006);
    #1 checkOutput("wr6_ready", 32'(ready1), 32'h8);
    @(negedge clk);
    idleAll();
    rst = 1'b1;

    // All four requesters hold reads from reset: pairs {0,1},{2,3},{0,1}.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 10'd5, 4'h0, 32'd0);
    applyStimulus(1, 1'b1, 10'd6, 4'h0, 32'd0);
    applyStimulus(2, 1'b1, 10'd5, 4'h0, 32'd0);
    applyStimulus(3, 1'b1, 10'd6, 4'h0, 32'd0);
    #1 checkOutput("rr_grant_1", 32'(ready1), 32'h3);
    @(negedge clk);
    #1;
    checkOutput("rr_grant_2", 32'(ready1), 32'hC);
    checkOutput("rr_rsp_none_yet", 32'(valid1), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rr_grant_3", 32'(ready1), 32'h3);
    checkOutput("rr_rsp_1", 32'(valid1), 32'h3);
    checkOutput("rr_data_p0", rdata1[0], 32'hDEADABEF);
    checkOutput("rr_data_p1", rdata1[1], 32'hCAFE0006);
    @(negedge clk);
    idleAll();
    #1;
    checkOutput("rr_rsp_2", 32'(valid1), 32'hC);
    checkOutput("rr_data_p2", rdata1[2], 32'hDEADABEF);
    checkOutput("rr_data_p3", rdata1[3], 32'hCAFE0006);
    @(negedge clk);
    #1 checkOutput("rr_rsp_3", 32'(valid1), 32'h3);
    @(negedge clk);
    #1 checkOutput("rr_rsp_done", 32'(valid1), 32'h0);

    // Write/read on the same address in one cycle: port B is withheld.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 10'd9, 4'hF, 32'h12345678);
    applyStimulus(1, 1'b1, 10'd9, 4'h0, 32'd0);
    #1 checkOutput("conflict_ready", 32'(ready1), 32'h1);
    @(negedge clk);
    applyStimulus(0, 1'b0, 10'd0, 4'h0, 32'd0);
    #1 checkOutput("conflict_retry_ready", 32'(ready1), 32'h2);
    @(negedge clk);
    idleAll();
    #1;
    checkOutput("conflict_pd0_valid", 32'(valid0), 32'h2);
    checkOutput("conflict_pd0_data", rdata0[1], 32'h12345678);
    checkOutput("conflict_pd1_not_early", 32'(valid1), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("conflict_pd1_valid", 32'(valid1), 32'h2);
    checkOutput("conflict_pd1_data", rdata1[1], 32'h12345678);

    // Read on port 3 dropped by a reset in the following cycle.
    @(negedge clk);
    applyStimulus(3, 1'b1, 10'd5, 4'h0, 32'd0);
    #1 checkOutput("drop_rd_ready", 32'(ready1), 32'h8);
    @(negedge clk);
    idleAll();
    rst = 1'b1;
    applyStimulus(0, 1'b1, 10'd5, 4'h0, 32'd0);
    #1 checkOutput("drop_ready_in_rst", 32'(ready1), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idleAll();
    #1 checkOutput("drop_no_rsp_a", 32'(valid1), 32'h0);
    @(negedge clk);
    #1 checkOutput("drop_no_rsp_b", 32'(valid1), 32'h0);
    @(negedge clk);
    applyStimulus(0, 1'b1, 10'd5, 4'h0, 32'd0);
    #1 checkOutput("post_rst_rd_ready", 32'(ready1), 32'h1);
    @(negedge clk);
    idleAll();
    @(negedge clk);
    #1;
    checkOutput("post_rst_rd_valid", 32'(valid1), 32'h1);
    checkOutput("post_rst_rd_data", rdata1[0], 32'hDEADABEF);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
